// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with parameterised width and depth, and a choice of read
//   mode: registered, or first-word-fall-through (FWFT). It has almost-full
//   and almost-empty thresholds, an occupancy count, sticky overflow and
//   underflow flags, and a synchronous flush.
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (power of two, >= 2)
//   FWFT      0: registered read, 1: head word shown combinationally
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//
// Ports
//   clock         rising-edge clock
//   rst           asynchronous reset, active low
//   flush         synchronous clear of the pointers and count
//   err_clr       synchronous clear of the sticky error flags
//   wr / din      write request and write data
//   rd / dout     read request and read data
//   full, empty, almost_full, almost_empty   status flags, decoded from count
//   count         occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       err_clr,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Storage. It has no reset, so it can map onto RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic wr_acc, rd_acc;
    logic ovf_set, udf_set;

    // ------------------------------------------------------------------
    // Status flags. They decode from count alone, so they update on the
    // same edge as count.
    // ------------------------------------------------------------------
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // ------------------------------------------------------------------
    // Accept logic, from the state before the edge. A write into a full
    // FIFO is allowed when a read leaves the same cycle. The read takes the
    // old word at rptr and the write puts the new word in the same slot.
    // While flushing, both requests are ignored and raise no error.
    // ------------------------------------------------------------------
    assign wr_acc  = wr & ~flush & (~full | rd);
    assign rd_acc  = rd & ~flush & ~empty;

    assign ovf_set = wr & ~flush & ~wr_acc;
    assign udf_set = rd & ~flush & ~rd_acc;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // The pointers are exactly AW bits wide, so DEPTH-1 wraps to 0.
            if (wr_acc) wptr_d = wptr_q + AW'(1);
            if (rd_acc) rptr_d = rptr_q + AW'(1);
            if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
            else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
        end
    end

    // A new error event takes priority over a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        udf_d = udf_set | (udf_q & ~err_clr);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) mem[wptr_q] <= din;
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (FWFT == 0) begin : g_reg_read
        logic [WIDTH-1:0] dout_q;

        // The read samples the array before the write, so a read and a
        // write to the same slot (full FIFO) return the old word. dout
        // holds between reads, and also through a flush.
        always_ff @(posedge clock or negedge rst) begin
            if (!rst)        dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rptr_q];
        end

        assign dout = dout_q;
    end else begin : g_fwft_read
        // The head word is shown whenever data is held. Reset clears count,
        // so dout returns to zero at once, without waiting for a clock edge.
        assign dout = empty ? '0 : mem[rptr_q];
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Drives a registered-read instance and an FWFT instance with the same
//   stimulus. Both are compared against one queue-based reference model.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;
    localparam int AEL   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             rst   = 1'b0;
    logic             flush = 1'b0;
    logic             err_clr = 1'b0;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic [WIDTH-1:0] din = '0;

    logic [WIDTH-1:0] dout_r, dout_f;
    logic             full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
    logic             full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [CW-1:0]    count_r, count_f;

    always #5 clock = ~clock;

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_reg (
        .clock(clock), .rst(rst), .flush(flush), .err_clr(err_clr),
        .wr(wr), .din(din), .rd(rd), .dout(dout_r),
        .full(full_r), .empty(empty_r), .almost_full(af_r), .almost_empty(ae_r),
        .count(count_r), .overflow(ovf_r), .underflow(udf_r)
    );

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clock(clock), .rst(rst), .flush(flush), .err_clr(err_clr),
        .wr(wr), .din(din), .rd(rd), .dout(dout_f),
        .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(count_f), .overflow(ovf_f), .underflow(udf_f)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout_r;
    bit               m_ovf, m_udf;

    function automatic logic [WIDTH-1:0] m_head();
        return (mq.size() == 0) ? '0 : mq[0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_dout_r = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
    endtask

    // Applies the inputs currently driven to the model, as one clock edge.
    task automatic model_step();
        bit set_o, set_u, wa, ra;
        set_o = 1'b0;
        set_u = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            wa = wr && (mq.size() < DEPTH || rd);
            ra = rd && (mq.size() > 0);
            set_o = wr && !wa;
            set_u = rd && !ra;
            if (ra) m_dout_r = mq.pop_front();
            if (wa) mq.push_back(din);
        end
        m_ovf = set_o ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_udf = set_u ? 1'b1 : (err_clr ? 1'b0 : m_udf);
    endtask

    task automatic compare_all(input string ph);
        int n;
        n = mq.size();
        check({ph, ":count_r"}, 32'(count_r), 32'(n));
        check({ph, ":count_f"}, 32'(count_f), 32'(n));
        check({ph, ":full"},    {30'd0, full_r,  full_f},  {30'd0, {2{n == DEPTH}}});
        check({ph, ":empty"},   {30'd0, empty_r, empty_f}, {30'd0, {2{n == 0}}});
        check({ph, ":af"},      {30'd0, af_r,    af_f},    {30'd0, {2{n >= AFL}}});
        check({ph, ":ae"},      {30'd0, ae_r,    ae_f},    {30'd0, {2{n <= AEL}}});
        check({ph, ":ovf"},     {30'd0, ovf_r,   ovf_f},   {30'd0, {2{m_ovf}}});
        check({ph, ":udf"},     {30'd0, udf_r,   udf_f},   {30'd0, {2{m_udf}}});
        check({ph, ":dout_r"},  32'(dout_r), 32'(m_dout_r));
        check({ph, ":dout_f"},  32'(dout_f), 32'(m_head()));
    endtask

    // Drives one cycle of stimulus, then checks 1 time unit after the edge.
    task automatic step(input string ph, input bit w, input bit r, input logic [WIDTH-1:0] d,
                        input bit fl, input bit ec);
        wr = w; rd = r; din = d; flush = fl; err_clr = ec;
        model_step();
        @(posedge clock);
        #1;
        compare_all(ph);
    endtask

    // Asserts reset between edges and checks that it acts immediately.
    task automatic async_reset(input string ph);
        wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check({ph, ":rst_count"}, 32'(count_r), 32'd0);
        check({ph, ":rst_empty"}, {30'd0, empty_r, empty_f}, 32'd3);
        check({ph, ":rst_dout"},  {16'd0, dout_r, dout_f}, 32'd0);
        compare_all({ph, ":rst"});
        @(posedge clock);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        rst = 1'b1;
        @(posedge clock);
        #1;

        // Fill with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1, 0, WIDTH'(i), 0, 0);
            check("fill_count", 32'(count_r), 32'(i + 1));
            check("fill_af", 32'(af_r), 32'(i + 1 >= 14));
        end
        check("fill_full", 32'(full_r), 32'd1);
        check("fill_ovf", 32'(ovf_r), 32'd0);

        // A write into the full FIFO is rejected, and overflow sticks until err_clr.
        step("wfull", 1, 0, 8'hAA, 0, 0);
        check("wfull_ovf", 32'(ovf_r), 32'd1);
        step("hold", 0, 0, 8'h00, 0, 0);
        check("hold_ovf", 32'(ovf_r), 32'd1);
        step("eclr", 0, 0, 8'h00, 0, 1);
        check("eclr_ovf", 32'(ovf_r), 32'd0);

        // Drain.
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 1, 8'h00, 0, 0);
            check("drain_dout", 32'(dout_r), 32'(i));
        end
        check("drain_empty", 32'(empty_r), 32'd1);
        step("udf", 0, 1, 8'h00, 0, 0);
        check("udf_flag", 32'(udf_r), 32'd1);
        check("udf_hold", 32'(dout_r), 32'h0F);
        step("eclr2", 0, 0, 8'h00, 0, 1);

        // Read and write together while full: the read returns the old word.
        for (int i = 0; i < DEPTH; i++) step("refill", 1, 0, WIDTH'(i), 0, 0);
        step("rdwr", 1, 1, 8'h55, 0, 0);
        check("rdwr_dout", 32'(dout_r), 32'h00);
        check("rdwr_count", 32'(count_r), 32'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            step("wrap", 0, 1, 8'h00, 0, 0);
            check("wrap_dout", 32'(dout_r), (i == DEPTH) ? 32'h55 : 32'(i));
        end

        // FWFT: the head word appears the cycle after it is written.
        step("fwft_w", 1, 0, 8'h3C, 0, 0);
        check("fwft_dout", 32'(dout_f), 32'h3C);
        check("fwft_nempty", 32'(empty_f), 32'd0);
        step("fwft_r", 0, 1, 8'h00, 0, 0);
        check("fwft_empty", 32'(empty_f), 32'd1);
        check("fwft_zero", 32'(dout_f), 32'd0);

        // Read and write together while empty: the write goes in, the read underflows.
        step("rw_empty", 1, 1, 8'h77, 0, 0);
        check("rwe_count", 32'(count_r), 32'd1);
        check("rwe_udf", 32'(udf_r), 32'd1);
        step("eclr3", 0, 0, 8'h00, 0, 1);

        // Flush in mid-operation, then an asynchronous reset in mid-operation.
        for (int i = 0; i < 4; i++) step("pre_fl", 1, 0, WIDTH'(8'h90 + i), 0, 0);
        step("flush", 1, 0, 8'hEE, 1, 0);
        check("flush_count", 32'(count_r), 32'd0);
        check("flush_ovf", 32'(ovf_r), 32'd0);
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, WIDTH'(8'hA0 + i), 0, 0);
        async_reset("midrst");

        // Randomised traffic, with the write/read bias changing per phase.
        for (int ph = 0; ph < 12; ph++) begin
            int wp, rp;
            wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 55;
            rp = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
            for (int c = 0; c < 150; c++) begin
                step("rand",
                     $urandom_range(99) < wp,
                     $urandom_range(99) < rp,
                     WIDTH'($urandom),
                     $urandom_range(99) < 2,
                     $urandom_range(99) < 4);
            end
            if (ph % 4 == 3) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
